mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore control FSM for a shared-memory multi-cycle datapath.
// Sequences fetch/decode/execute for lw, sw, R-type, beq, j and addi. It
// watches every memory-wait state with a stall counter and parks in a sticky
// error state if memory stays silent for too long.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   opCode[5:0] instruction opcode from the instruction register
//   memReady    memory handshake, 1 = access completes this cycle
//   pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
//   regDst, regWrite, aluSrcA, aluSrcB[1:0], aluOp[1:0], pcSource[1:0]
//               datapath control strobes decoded from state
//   state[3:0]  current state encoding (debug)
//   retire      one-cycle pulse in the last cycle of a completed instruction
//   fault       sticky memory-timeout flag
module mc_ctrl #(
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic [3:0] state,
    output logic       retire,
    output logic       fault
);

    // A limit of 0 still needs a 1-bit counter.
    localparam int unsigned CNT_W = (STALL_LIMIT == 0) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STALL_LIMIT);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_ERR    = 4'd15
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;
    logic             fault_q;
    logic             fault_d;
    logic             mem_wait;

    logic             pc_write_dec;
    logic             pc_write_cond_dec;
    logic             ior_d_dec;
    logic             mem_read_dec;
    logic             mem_write_dec;
    logic             ir_write_dec;
    logic             mem_to_reg_dec;
    logic             reg_dst_dec;
    logic             reg_write_dec;
    logic             alu_src_a_dec;
    logic [1:0]       alu_src_b_dec;
    logic [1:0]       alu_op_dec;
    logic [1:0]       pc_source_dec;
    logic             retire_dec;

    // State, stall counter and fault flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            stall_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            fault_q <= fault_d;
        end
    end

    // Next-state, stall supervision and Moore output decode.
    always_comb begin
        state_d           = state_q;
        stall_d           = '0;
        fault_d           = fault_q;
        mem_wait          = 1'b0;
        pc_write_dec      = 1'b0;
        pc_write_cond_dec = 1'b0;
        ior_d_dec         = 1'b0;
        mem_read_dec      = 1'b0;
        mem_write_dec     = 1'b0;
        ir_write_dec      = 1'b0;
        mem_to_reg_dec    = 1'b0;
        reg_dst_dec       = 1'b0;
        reg_write_dec     = 1'b0;
        alu_src_a_dec     = 1'b0;
        alu_src_b_dec     = 2'b00;
        alu_op_dec        = 2'b00;
        pc_source_dec     = 2'b00;
        retire_dec        = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_wait      = 1'b1;
                mem_read_dec  = 1'b1;
                alu_src_b_dec = 2'b01;
                ir_write_dec  = memReady;
                pc_write_dec  = memReady;
                if (memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_dec = 2'b11;
                case (opCode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_dec = 1'b1;
                alu_src_b_dec = 2'b10;
                // An opcode that changed under us is dropped rather than guessed.
                if (opCode == OP_LW)      state_d = S_MEMRD;
                else if (opCode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                mem_wait     = 1'b1;
                mem_read_dec = 1'b1;
                ior_d_dec    = 1'b1;
                if (memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_dec  = 1'b1;
                mem_to_reg_dec = 1'b1;
                retire_dec     = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                mem_wait      = 1'b1;
                mem_write_dec = 1'b1;
                ior_d_dec     = 1'b1;
                retire_dec    = memReady;
                if (memReady) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a_dec = 1'b1;
                alu_op_dec    = 2'b10;
                state_d       = S_RWB;
            end
            S_RWB: begin
                reg_write_dec = 1'b1;
                reg_dst_dec   = 1'b1;
                retire_dec    = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_dec     = 1'b1;
                alu_op_dec        = 2'b01;
                pc_write_cond_dec = 1'b1;
                pc_source_dec     = 2'b01;
                retire_dec        = 1'b1;
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                pc_write_dec  = 1'b1;
                pc_source_dec = 2'b10;
                retire_dec    = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_dec = 1'b1;
                alu_src_b_dec = 2'b10;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_dec = 1'b1;
                retire_dec    = 1'b1;
                state_d       = S_FETCH;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Timeout: a ready on the limit cycle still wins over the error path.
        if (mem_wait && !memReady && (stall_q == CNT_LIMIT)) begin
            state_d = S_ERR;
        end

        // Count consecutive not-ready cycles inside one memory-wait state.
        if (mem_wait && !memReady && (state_d == state_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (state_d == S_ERR) begin
            fault_d = 1'b1;
        end
    end

    // Strobes are held low for the whole time reset is asserted.
    assign pcWrite     = reset & pc_write_dec;
    assign pcWriteCond = reset & pc_write_cond_dec;
    assign iorD        = reset & ior_d_dec;
    assign memRead     = reset & mem_read_dec;
    assign memWrite    = reset & mem_write_dec;
    assign irWrite     = reset & ir_write_dec;
    assign memToReg    = reset & mem_to_reg_dec;
    assign regDst      = reset & reg_dst_dec;
    assign regWrite    = reset & reg_write_dec;
    assign aluSrcA     = reset & alu_src_a_dec;
    assign aluSrcB     = reset ? alu_src_b_dec : 2'b00;
    assign aluOp       = reset ? alu_op_dec    : 2'b00;
    assign pcSource    = reset ? pc_source_dec : 2'b00;
    assign retire      = reset & retire_dec;
    assign state       = state_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl with hand-computed per-cycle
// expectations for state, the packed control word and retire.
// Control word bit order (MSB..LSB): pcWrite, pcWriteCond, iorD, memRead,
// memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA, aluSrcB[1:0],
// aluOp[1:0], pcSource[1:0].
module tb_mc_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] opCode;
    logic       memReady;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic [3:0] state;
    logic       retire;
    logic       fault;
    logic [15:0] ctl;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [15:0] C_FETCH  = 16'h9410;
    localparam logic [15:0] C_FETCHW = 16'h1010;
    localparam logic [15:0] C_DECODE = 16'h0030;
    localparam logic [15:0] C_MEMADR = 16'h0060;
    localparam logic [15:0] C_MEMRD  = 16'h3000;
    localparam logic [15:0] C_MEMWB  = 16'h0280;
    localparam logic [15:0] C_MEMWR  = 16'h2800;
    localparam logic [15:0] C_EXEC   = 16'h0048;
    localparam logic [15:0] C_RWB    = 16'h0180;
    localparam logic [15:0] C_BRANCH = 16'h4045;
    localparam logic [15:0] C_JUMP   = 16'h8002;
    localparam logic [15:0] C_ADDIWB = 16'h0080;

    mc_ctrl #(.STALL_LIMIT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .opCode      (opCode),
        .memReady    (memReady),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .iorD        (iorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .memToReg    (memToReg),
        .regDst      (regDst),
        .regWrite    (regWrite),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .aluOp       (aluOp),
        .pcSource    (pcSource),
        .state       (state),
        .retire      (retire),
        .fault       (fault)
    );

    assign ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                  memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset;
        reset = 1'b0; memReady = 1'b1; opCode = 6'b100011;
        @(negedge clk); #1;
        n_vec++; if (state !== 4'd0) begin $display("FAIL reset state got %0d want 0", state); n_err++; end
        n_vec++; if (ctl !== 16'h0000) begin $display("FAIL reset strobes got %h want 0000", ctl); n_err++; end
        n_vec++; if (retire !== 1'b0) begin $display("FAIL reset retire got %b want 0", retire); n_err++; end
        n_vec++; if (fault !== 1'b0) begin $display("FAIL reset fault got %b want 0", fault); n_err++; end
        @(negedge clk);
    endtask

    task automatic test_lw;
        int e_st [5];
        logic [15:0] e_ctl [5];
        logic e_ret [5];
        int pulses;
        e_st  = '{0, 1, 2, 3, 4};
        e_ctl = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB};
        e_ret = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        pulses = 0;
        reset = 1'b1; memReady = 1'b1; opCode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (retire === 1'b1) pulses++;
            n_vec++; if (state !== 4'(e_st[i])) begin $display("FAIL lw state cyc %0d got %0d want %0d", i, state, e_st[i]); n_err++; end
            n_vec++; if (ctl !== e_ctl[i]) begin $display("FAIL lw ctl cyc %0d got %h want %h", i, ctl, e_ctl[i]); n_err++; end
            n_vec++; if (retire !== e_ret[i]) begin $display("FAIL lw retire cyc %0d got %b want %b", i, retire, e_ret[i]); n_err++; end
            @(negedge clk);
        end
        n_vec++; if (pulses != 1) begin $display("FAIL lw retire count got %0d want 1", pulses); n_err++; end
    endtask

    task automatic test_sw_stall;
        int e_st [7];
        logic [15:0] e_ctl [7];
        logic e_ret [7];
        logic rdy [7];
        e_st  = '{0, 1, 2, 5, 5, 5, 5};
        e_ctl = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWR, C_MEMWR, C_MEMWR, C_MEMWR};
        e_ret = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rdy   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opCode = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            memReady = rdy[i];
            #1;
            n_vec++; if (state !== 4'(e_st[i])) begin $display("FAIL sw state cyc %0d got %0d want %0d", i, state, e_st[i]); n_err++; end
            n_vec++; if (ctl !== e_ctl[i]) begin $display("FAIL sw ctl cyc %0d got %h want %h", i, ctl, e_ctl[i]); n_err++; end
            n_vec++; if (retire !== e_ret[i]) begin $display("FAIL sw retire cyc %0d got %b want %b", i, retire, e_ret[i]); n_err++; end
            @(negedge clk);
        end
        memReady = 1'b1;
    endtask

    task automatic test_branch_jump;
        int e_st [6];
        logic [15:0] e_ctl [6];
        logic e_ret [6];
        logic [5:0] op [6];
        e_st  = '{0, 1, 8, 0, 1, 9};
        e_ctl = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH, C_DECODE, C_JUMP};
        e_ret = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        op    = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010};
        memReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            opCode = op[i];
            #1;
            n_vec++; if (state !== 4'(e_st[i])) begin $display("FAIL br/j state cyc %0d got %0d want %0d", i, state, e_st[i]); n_err++; end
            n_vec++; if (ctl !== e_ctl[i]) begin $display("FAIL br/j ctl cyc %0d got %h want %h", i, ctl, e_ctl[i]); n_err++; end
            n_vec++; if (retire !== e_ret[i]) begin $display("FAIL br/j retire cyc %0d got %b want %b", i, retire, e_ret[i]); n_err++; end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype_addi;
        int e_st [8];
        logic [15:0] e_ctl [8];
        logic e_ret [8];
        logic [5:0] op [8];
        e_st  = '{0, 1, 6, 7, 0, 1, 10, 11};
        e_ctl = '{C_FETCH, C_DECODE, C_EXEC, C_RWB, C_FETCH, C_DECODE, C_MEMADR, C_ADDIWB};
        e_ret = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        op    = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
                  6'b001000, 6'b001000, 6'b001000, 6'b001000};
        memReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            opCode = op[i];
            #1;
            n_vec++; if (state !== 4'(e_st[i])) begin $display("FAIL r/addi state cyc %0d got %0d want %0d", i, state, e_st[i]); n_err++; end
            n_vec++; if (ctl !== e_ctl[i]) begin $display("FAIL r/addi ctl cyc %0d got %h want %h", i, ctl, e_ctl[i]); n_err++; end
            n_vec++; if (retire !== e_ret[i]) begin $display("FAIL r/addi retire cyc %0d got %b want %b", i, retire, e_ret[i]); n_err++; end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal;
        memReady = 1'b1; opCode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (state !== ((i == 1) ? 4'd1 : 4'd0)) begin $display("FAIL illegal state cyc %0d got %0d", i, state); n_err++; end
            n_vec++; if (regWrite !== 1'b0 || memWrite !== 1'b0 || retire !== 1'b0) begin
                $display("FAIL illegal strobes cyc %0d got regWrite=%b memWrite=%b retire=%b want 0", i, regWrite, memWrite, retire); n_err++;
            end
            if (i < 2) @(negedge clk);
        end
    endtask

    task automatic test_stall_boundary;
        // Enters in a fresh FETCH; ready arrives on the 16th waiting cycle.
        opCode = 6'b111111;
        for (int i = 1; i <= 16; i++) begin
            memReady = (i == 16);
            #1;
            n_vec++; if (state !== 4'd0 || fault !== 1'b0) begin $display("FAIL boundary cyc %0d got state=%0d fault=%b want 0/0", i, state, fault); n_err++; end
            @(negedge clk);
        end
        memReady = 1'b1;
        #1;
        n_vec++; if (state !== 4'd1) begin $display("FAIL boundary ready-on-limit got state %0d want 1", state); n_err++; end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        opCode = 6'b000000;
        for (int i = 1; i <= 16; i++) begin
            memReady = 1'b0;
            #1;
            n_vec++; if (state !== 4'd0 || ctl !== C_FETCHW) begin $display("FAIL timeout wait cyc %0d got state=%0d ctl=%h want 0/%h", i, state, ctl, C_FETCHW); n_err++; end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            memReady = (i != 0);
            #1;
            n_vec++; if (state !== 4'd15 || fault !== 1'b1) begin $display("FAIL timeout err cyc %0d got state=%0d fault=%b want 15/1", i, state, fault); n_err++; end
            n_vec++; if (ctl !== 16'h0000 || retire !== 1'b0) begin $display("FAIL timeout err strobes cyc %0d got ctl=%h retire=%b want 0", i, ctl, retire); n_err++; end
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (state !== 4'd0 || fault !== 1'b0) begin $display("FAIL err exit by reset got state=%0d fault=%b want 0/0", state, fault); n_err++; end
        @(negedge clk);
    endtask

    task automatic test_async_reset_memrd;
        reset = 1'b1; memReady = 1'b1; opCode = 6'b100011;
        for (int i = 0; i < 3; i++) @(negedge clk);
        memReady = 1'b0;
        #1;
        n_vec++; if (state !== 4'd3 || ctl !== C_MEMRD) begin $display("FAIL memrd hold got state=%0d ctl=%h want 3/%h", state, ctl, C_MEMRD); n_err++; end
        @(negedge clk);
        #1;
        n_vec++; if (state !== 4'd3) begin $display("FAIL memrd stall got state=%0d want 3", state); n_err++; end
        #1 reset = 1'b0;
        #1;
        n_vec++; if (state !== 4'd0 || ctl !== 16'h0000 || retire !== 1'b0) begin
            $display("FAIL async reset got state=%0d ctl=%h retire=%b want 0/0000/0", state, ctl, retire); n_err++;
        end
        @(negedge clk);
        memReady = 1'b1;
        #1;
        n_vec++; if (ctl !== 16'h0000) begin $display("FAIL reset gating got ctl=%h want 0000", ctl); n_err++; end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++; if (state !== 4'd0 || ctl !== C_FETCH) begin $display("FAIL post-reset fetch got state=%0d ctl=%h want 0/%h", state, ctl, C_FETCH); n_err++; end
        @(negedge clk);
        #1;
        n_vec++; if (state !== 4'd1) begin $display("FAIL post-reset first edge got state=%0d want 1", state); n_err++; end
    endtask

    initial begin
        reset = 1'b0; memReady = 1'b0; opCode = 6'b000000;
        @(negedge clk);
        test_reset;
        test_lw;
        test_sw_stall;
        test_branch_jump;
        test_rtype_addi;
        test_illegal;
        test_stall_boundary;
        test_timeout;
        test_async_reset_memrd;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
